// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store bus adapter.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    function automatic logic [3:0] be_gen(input size_e size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << offset;
            HALF:    be = offset[1] ? 4'b1100 : 4'b0011;
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] offset,
                                                input size_e size, input logic is_unsigned);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {offset, 3'b000};
        case (size)
            BYTE:    res = is_unsigned ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            HALF:    res = is_unsigned ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            WORD:    res = shifted;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational store-lane replication / byte enables and load extraction.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic        st_is_store_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  size_e       ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_result_o
);

    // Loads share the store byte-enable pattern but never drive write data.
    always_comb begin
        st_be_o    = be_gen(st_size_i, st_off_i);
        st_wdata_o = 32'h0000_0000;
        if (st_is_store_i) begin
            case (st_size_i)
                BYTE:    st_wdata_o = {4{st_data_i[7:0]}};
                HALF:    st_wdata_o = {2{st_data_i[15:0]}};
                WORD:    st_wdata_o = st_data_i;
                default: st_wdata_o = 32'h0000_0000;
            endcase
        end else begin
            st_wdata_o = 32'h0000_0000;
        end
    end

    assign ld_result_o = load_extend(ld_rdata_i, ld_off_i, ld_size_i, ld_unsigned_i);

endmodule

// File: rtl/lsu_bus_adapter.sv
// Multi-cycle load/store unit: checks alignment, drives a req/gnt/rvalid word bus
// and stalls the core until the access completes, faults or times out.
module lsu_bus_adapter
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        sb,
    input  logic        sh,
    input  logic        sw,
    input  logic        lb,
    input  logic        lh,
    input  logic        lw,
    input  logic        lbu,
    input  logic        lhu,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] read_data,
    output logic        access_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    state_e            state_q;
    size_e             size_q;
    logic              unsigned_q;
    logic [1:0]        off_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              req_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              fault_q;
    logic              load_valid_q;
    logic [31:0]       rdata_q;

    logic [3:0]        strobe_cnt_s;
    size_e             size_s;
    logic              is_store_s;
    logic              fault_s;
    logic              accept_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       load_s;

    // Decode strobes into size/sign and run the fault checks for a new request.
    always_comb begin
        strobe_cnt_s = 4'(sb) + 4'(sh) + 4'(sw) + 4'(lb) + 4'(lh) + 4'(lw) + 4'(lbu) + 4'(lhu);
        is_store_s   = sb | sh | sw;
        if (sw | lw) begin
            size_s = WORD;
        end else if (sh | lh | lhu) begin
            size_s = HALF;
        end else begin
            size_s = BYTE;
        end
        fault_s  = req_valid && ((strobe_cnt_s != 4'd1) ||
                                 ((sh | lh | lhu) && address[0]) ||
                                 ((sw | lw) && (address[1:0] != 2'b00)));
        accept_s = (state_q == IDLE) && req_valid && !fault_s;
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    lsu_lane_align u_align (
        .st_size_i     (size_s),
        .st_off_i      (address[1:0]),
        .st_is_store_i (is_store_s),
        .st_data_i     (write_data),
        .st_be_o       (be_s),
        .st_wdata_o    (wdata_s),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (unsigned_q),
        .ld_rdata_i    (mem_rdata),
        .ld_result_o   (load_s)
    );

    // Access FSM with registered bus, status and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            size_q       <= BYTE;
            unsigned_q   <= 1'b0;
            off_q        <= 2'b00;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0000_0000;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0000_0000;
            fault_q      <= 1'b0;
            load_valid_q <= 1'b0;
            rdata_q      <= 32'h0000_0000;
        end else begin
            fault_q      <= 1'b0;
            load_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fault_s) begin
                        fault_q <= 1'b1;
                    end else if (accept_s) begin
                        size_q     <= size_s;
                        unsigned_q <= lbu | lhu;
                        off_q      <= address[1:0];
                        we_q       <= is_store_s;
                        addr_q     <= {address[31:2], 2'b00};
                        be_q       <= be_s;
                        wdata_q    <= wdata_s;
                        cnt_q      <= '0;
                        req_q      <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    if (mem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? DONE : WAIT;
                    end else if (cnt_d == TMO) begin
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (mem_rvalid) begin
                        rdata_q      <= load_s;
                        load_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else if (cnt_d == TMO) begin
                        fault_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The accept cycle must stall before the FSM has left IDLE.
    assign stall        = accept_s || (state_q == REQ) || (state_q == WAIT);
    assign load_valid   = load_valid_q;
    assign read_data    = rdata_q;
    assign access_fault = fault_q;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Multi-cycle load/store unit. Sits downstream of the ALU, which supplies the effective address, and the control unit, which supplies the sb/sh/sw/lb/lh/lw/lbu/lhu strobes.
- Upstream of the writeback 8:1 mux: its read_data replaces the combinational data_mem load result.
- Drives a word-addressed request/grant/rvalid memory bus with byte enables.
- Stalls the core until each access completes, faults, or times out.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ plus WAIT before the access is abandoned with a fault.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  current instruction is a memory op
- sb, sh, sw, lb, lh, lw, lbu, lhu  in  1 each  one-hot op strobes from control_unit
- address  in  32  ALU effective address (byte)
- write_data  in  32  rs2 value for stores
- stall  out  1  hold PC/regfile write
- load_valid  out  1  read_data valid this cycle; gates regfile write
- read_data  out  32  aligned, extended load result
- access_fault  out  1  one-cycle pulse on fault (misaligned, illegal strobes, timeout)
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  32  {address[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  load data returned
- mem_rdata  in  32  load data word

Behaviour:
- Reset: state = IDLE. All outputs are 0: stall, load_valid, read_data, access_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
- Reset asserted mid-access aborts immediately; no completion or fault is reported afterwards.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, req_valid = 0: no action.
- IDLE, req_valid = 1, fault check, in priority order:
  - strobe count != 1 -> fault
  - lh/lhu/sh with address[0] = 1 -> fault
  - lw/sw with address[1:0] != 0 -> fault
- On fault: access_fault = 1 for one cycle, stall = 0, no bus activity, stay in IDLE.
- On a legal access: latch op, address[1:0], mem_addr, mem_be, mem_wdata; go to REQ.
  - stall = 1 combinationally in that same cycle.
- Store lanes:
  - sb: wdata = {4{wd[7:0]}}, be = 4'b0001 << addr[1:0]
  - sh: wdata = {2{wd[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011
  - sw: wdata = wd, be = 4'b1111
- Loads drive the same be pattern as the equivalent-width store; mem_wdata = 0 for loads.
- REQ: mem_req = 1 and all bus outputs held stable until mem_gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - mem_req drops the cycle after gnt.
- WAIT: on mem_rvalid, shift = mem_rdata >> (8*addr[1:0]).
  - lb: sign-extend [7:0]; lbu: zero-extend [7:0]
  - lh: sign-extend [15:0]; lhu: zero-extend [15:0]
  - lw: whole word
  - Register the result into read_data; go to DONE.
- mem_rvalid outside WAIT is ignored. mem_gnt and mem_rvalid in the same cycle while in REQ: the grant is taken, the rvalid is ignored.
- DONE: stall = 0 for one cycle.
  - Loads: load_valid = 1 for that cycle.
  - Then return to IDLE. req_valid is not sampled in DONE, so back-to-back ops lose one cycle.
- read_data holds its value until the next load completes.
- stall = 1 in REQ and WAIT, and in IDLE on an accepted legal request.
- Timeout: the counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When count == TIMEOUT_CYCLES: access_fault pulse, mem_req = 0, go to IDLE, no load_valid.
- Latency with immediate gnt and rvalid the next cycle:
  - Store: 2 stall cycles (IDLE-accept, REQ), then DONE.
  - Load: 3 stall cycles, then DONE with load_valid.

Decomposition:
- Package lsu_pkg holds:
  - state enum (IDLE, REQ, WAIT, DONE)
  - op-size enum (BYTE, HALF, WORD)
  - function be_gen(size, offset)
  - function load_extend(word, offset, size, is_unsigned)
- Optional sub-module lsu_lane_align: combinational store replication and load extraction. Everything else lives in a single module.

Test Plan:
- sb, address = 0x103, write_data = 0x000000A5, gnt on first REQ cycle -> mem_addr = 0x100, be = 4'b1000, wdata = 0xA5A5A5A5, mem_we = 1; stall high 2 cycles; no load_valid.
- lb, address = 0x201, mem_rdata = 0x0000_80FF, rvalid 1 cycle after gnt -> read_data = 0xFFFFFF80, load_valid for 1 cycle; same with lbu -> 0x00000080.
- lh, address = 0x202, mem_rdata = 0x9234_0000 -> read_data = 0xFFFF9234; lhu -> 0x00009234; lw at 0x204 with rdata 0xDEADBEEF -> 0xDEADBEEF.
- lw at 0x102 -> access_fault pulse, mem_req stays 0, stall 0; sb and lw both high at 0x100 -> access_fault, no bus activity.
- lw with mem_gnt held 0, TIMEOUT_CYCLES = 4 -> access_fault exactly 4 cycles after entering REQ, then IDLE, stall 0.
- Assert rst during WAIT with rvalid arriving the next cycle -> all outputs 0, no load_valid; a following sw at 0x300 completes normally.
